bus_arbiter3: RTL
=================

// Module: bus_arbiter3
// PURPOSE
//  Round-robin arbiter sharing one 16-bit datapath bus among three requesters.
//  Drives the 2-bit select of the registered 3-input 16-bit bus mux: sel 0=in1, 1=in2, 2=in3.
//  Sits beside the mux in the processor datapath; requesters are the ALU, memory and PC paths.
//  Grants are one-hot, held until the owner releases, and handed off with no idle bubble.
// PARAMETERS
//  NREQ      3   number of requesters (fixed; other values unsupported)
//  SEL_W     2   width of the mux select
//  MAX_HOLD  8   max cycles one owner may hold the bus (used only with ARB_TIMEOUT_EN)
// PORTS
//  clock        in   1      single system clock; all state updates on posedge
//  reset        in   1      synchronous, active-high reset
//  req          in   3      request per requester; level, held until granted/done
//  done         in   3      1-cycle release pulse from the current owner
//  grant        out  3      one-hot grant, registered; 3'b000 when idle
//  sel          out  2      mux control, registered, changes on the same edge as grant
//  busy         out  1      1 while any grant is asserted
//  timeout_err  out  1      1-cycle pulse on forced release (0 when macro absent)
// BEHAVIOUR
//  Reset (sync): grant=000, sel=0, busy=0, timeout_err=0, state=IDLE, last=2 (req0 wins first).
//  FSM: IDLE, OWNED.
//   IDLE : any req -> pick the first set bit scanning last+1, last+2, last (mod 3);
//          next edge: grant=onehot(pick), sel=pick, last=pick, state=OWNED. Latency 1 cycle.
//   OWNED: release = done[owner] | ~req[owner]. No release -> hold everything.
//          release & other req pending -> hand off on same edge (round-robin from owner).
//          release & none pending -> grant=000, busy=0, IDLE; sel holds last value.
//  Mux output is registered, so selected data appears 1 cycle after sel changes.
//  done on a non-owner bit: ignored. done and req[owner] both high: release wins.
//  Owner re-requesting on release edge: rotated past; regains only if no other req.
//  Reset mid-grant: grant drops on that edge, no timeout_err, last returns to 2.
//  grant is never multi-hot; sel never takes 3.
// CONFIGURATION
//  `ARB_TIMEOUT_EN defined: 4-bit hold counter clears on every new grant, +1 per OWNED cycle.
//   At count == MAX_HOLD-1 without release: forced release on next edge (same rules as
//   release), timeout_err=1 for exactly that cycle. MAX_HOLD=8 -> owner holds at most 8 cycles.
//  Not defined: no counter; an owner holds indefinitely; timeout_err tied 0.
// STRUCTURE
//  Package bus_arb_pkg: SEL_IN1/IN2/IN3 = 2'd0/1/2, state encodings ST_IDLE/ST_OWNED,
//   NREQ, SEL_W. The mux and its control decoder share these constants.
//  Sub-module rr_pick3: combinational; inputs req[2:0], last[1:0]; outputs valid, pick[1:0].
//   Used in IDLE and for handoff. The FSM, counter and registers stay in bus_arbiter3.
// TESTING
//  1 reset held 2 cycles, req=111 -> cycle after release: grant=001, sel=0; then done=001
//    -> grant=010, sel=1; done=010 -> grant=100, sel=2; done=100 -> grant=001 (wrap).
//  2 req=010 alone -> grant=010 next edge; drop req to 000 -> grant=000, busy=0, sel stays 1.
//  3 owner 0 granted, pulse done=110 (non-owner) -> grant stays 001; done=001 with req=101
//    -> grant=100 on the same edge, no idle cycle.
//  4 reset asserted while grant=100 -> next edge grant=000, sel=0; req=111 -> grant=001.
//  5 (ARB_TIMEOUT_EN, MAX_HOLD=8) req=011 held, no done -> grant=001 for 8 cycles,
//    then timeout_err=1 for 1 cycle, grant=010.
//  6 random req/done for 10k cycles -> grant is one-hot or zero, sel == index(grant) whenever
//    busy, no requester waits more than 2 ownerships.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared constants for the three-way bus arbiter and the datapath mux it steers.
// Select encodings, FSM state type and small index helpers live here.
package bus_arb_pkg;

   localparam int NREQ     = 3;
   localparam int SEL_W    = 2;
   localparam int MAX_HOLD = 8;

   localparam logic [SEL_W-1:0] SEL_IN1 = 2'd0;
   localparam logic [SEL_W-1:0] SEL_IN2 = 2'd1;
   localparam logic [SEL_W-1:0] SEL_IN3 = 2'd2;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_OWNED = 1'b1
   } arb_state_t;

   // Next requester index in round-robin order, wrapping 2 -> 0.
   function automatic logic [SEL_W-1:0] rr_next(input logic [SEL_W-1:0] idx);
      return (idx == SEL_IN3) ? SEL_IN1 : idx + 2'd1;
   endfunction

   function automatic logic [NREQ-1:0] onehot3(input logic [SEL_W-1:0] idx);
      case (idx)
         SEL_IN1: return 3'b001;
         SEL_IN2: return 3'b010;
         SEL_IN3: return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin picker: first set request scanning last+1, last+2, last.
// Shared by the idle-grant path and the same-edge handoff path.
module rr_pick3
   import bus_arb_pkg::*;
(
   input  logic [NREQ-1:0]  req,
   input  logic [SEL_W-1:0] last,
   output logic             valid,
   output logic [SEL_W-1:0] pick
);

   logic [SEL_W-1:0] w_c1;
   logic [SEL_W-1:0] w_c2;

   // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_c1  = rr_next(last);
      w_c2  = rr_next(w_c1);
      valid = |req;
      pick  = last;
      if (req[w_c1]) begin
         pick = w_c1;
      end else if (req[w_c2]) begin
         pick = w_c2;
      end
   end

endmodule

// File: rtl/bus_arbiter3.sv
// Round-robin arbiter driving the select of the registered 3-input 16-bit bus mux.
// Optional owner hold limit with forced release is enabled by defining ARB_TIMEOUT_EN.
module bus_arbiter3
   import bus_arb_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic [NREQ-1:0]  req,
   input  logic [NREQ-1:0]  done,
   output logic [NREQ-1:0]  grant,
   output logic [SEL_W-1:0] sel,
   output logic             busy,
   output logic             timeout_err
);

   arb_state_t       r_state, w_state_nxt;
   logic [NREQ-1:0]  r_grant, w_grant_nxt;
   logic [SEL_W-1:0] r_sel, w_sel_nxt;
   logic [SEL_W-1:0] r_last, w_last_nxt;
   logic             r_busy, w_busy_nxt;

   logic             w_valid;
   logic [SEL_W-1:0] w_pick;
   logic             w_release;
   logic             w_force;
   logic             w_new_grant;

   rr_pick3 u_pick (
      .req   (req),
      .last  (r_last),
      .valid (w_valid),
      .pick  (w_pick)
   );

   // While OWNED, r_last is the current owner.
   assign w_release = done[r_last] | ~req[r_last];

`ifdef ARB_TIMEOUT_EN
   localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

   logic [3:0] r_hold_cnt;
   logic       r_timeout;

   assign w_force = (r_state == ST_OWNED) && !w_release && (r_hold_cnt == HOLD_LAST);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_hold_cnt <= '0;
         r_timeout  <= 1'b0;
      end else begin
         r_timeout <= w_force;
         if (w_new_grant || r_state == ST_IDLE) begin
            r_hold_cnt <= '0;
         end else begin
            r_hold_cnt <= r_hold_cnt + 4'd1;
         end
      end
   end

   assign timeout_err = r_timeout;
`else
   assign w_force     = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_sel_nxt   = r_sel;
      w_last_nxt  = r_last;
      w_busy_nxt  = r_busy;
      w_new_grant = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_valid) begin
               w_new_grant = 1'b1;
            end
         end
         ST_OWNED: begin
            if (w_release || w_force) begin
               if (w_valid) begin
                  w_new_grant = 1'b1;
               end else begin
                  // sel deliberately keeps the last owner while idle.
                  w_state_nxt = ST_IDLE;
                  w_grant_nxt = '0;
                  w_busy_nxt  = 1'b0;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      if (w_new_grant) begin
         w_state_nxt = ST_OWNED;
         w_grant_nxt = onehot3(w_pick);
         w_sel_nxt   = w_pick;
         w_last_nxt  = w_pick;
         w_busy_nxt  = 1'b1;
      end
   end

   // NOTE: state registers use nonblocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_grant <= '0;
         r_sel   <= SEL_IN1;
         r_last  <= SEL_IN3;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_sel   <= w_sel_nxt;
         r_last  <= w_last_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   assign grant = r_grant;
   assign sel   = r_sel;
   assign busy  = r_busy;

endmodule
